// File: rtl/alarm_sequencer.sv
// alarm_sequencer: main FSM of the anti-theft car alarm.
// Tracks ignition and doors, selects the time parameter shown on `interval`,
// counts the fetched `value` down on 1 Hz ticks, and drives siren and LED.
// Optional feature: define ALARM_SIREN_PULSE_EN to pulse the siren at 1 Hz in
// ALARM. Without it the siren is held high for the whole of ALARM.
module alarm_sequencer #(
  parameter int unsigned TIMER_WIDTH   = 5,
  parameter int unsigned PARAM_LATENCY = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   ignition,
  input  logic                   driver_door,
  input  logic                   passenger_door,
  input  logic                   reprogram,
  input  logic                   one_hz_enable,
  input  logic [TIMER_WIDTH-1:0] value,
  output logic [1:0]             interval,
  output logic                   siren,
  output logic                   status_indicator,
  output logic [2:0]             state_out,
  output logic [TIMER_WIDTH-1:0] timer_count
);

  localparam int unsigned LCW = (PARAM_LATENCY > 1) ? $clog2(PARAM_LATENCY + 1) : 1;
  localparam logic [LCW-1:0] LOAD_START = LCW'(PARAM_LATENCY);
  localparam logic [LCW-1:0] LOAD_LAST  = LCW'(1);

  localparam logic [1:0] SEL_ARM_DELAY       = 2'b00;
  localparam logic [1:0] SEL_DRIVER_DELAY    = 2'b01;
  localparam logic [1:0] SEL_PASSENGER_DELAY = 2'b10;
  localparam logic [1:0] SEL_ALARM_ON        = 2'b11;

  typedef enum logic [2:0] {
    S_DISARMED     = 3'd0,
    S_ARM_WAIT     = 3'd1,
    S_ARMED        = 3'd2,
    S_TRIGGER_WAIT = 3'd3,
    S_ALARM        = 3'd4
  } state_t;

  state_t                 r_state;
  logic [1:0]             r_interval;
  logic                   r_siren;
  logic                   r_status;
  logic [TIMER_WIDTH-1:0] r_timer;
  logic [LCW-1:0]         r_load_cnt;
  logic                   r_loaded;

  state_t                 w_next_state;
  logic                   w_enter;
  logic                   w_abort;
  logic [1:0]             w_sel;
  logic                   w_any_door;
  logic                   w_expired;
  logic                   w_siren_next;
  logic                   w_status_next;

  assign w_any_door = driver_door | passenger_door;
  assign w_expired  = r_loaded & (r_timer == '0);

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_DISARMED;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode; w_enter flags any timed entry, including re-entry
  always_comb begin
    w_next_state = r_state;
    w_enter      = 1'b0;
    w_abort      = 1'b0;
    w_sel        = r_interval;
    if (ignition || reprogram) begin
      w_next_state = S_DISARMED;
      w_abort      = 1'b1;
    end else begin
      case (r_state)
        S_DISARMED: begin
          if (!w_any_door) begin
            w_next_state = S_ARM_WAIT;
            w_enter      = 1'b1;
            w_sel        = SEL_ARM_DELAY;
          end
        end
        S_ARM_WAIT: begin
          if (w_any_door) begin
            w_next_state = S_ARM_WAIT;
            w_enter      = 1'b1;
            w_sel        = SEL_ARM_DELAY;
          end else if (w_expired) begin
            w_next_state = S_ARMED;
          end
        end
        S_ARMED: begin
          if (driver_door) begin
            w_next_state = S_TRIGGER_WAIT;
            w_enter      = 1'b1;
            w_sel        = SEL_DRIVER_DELAY;
          end else if (passenger_door) begin
            w_next_state = S_TRIGGER_WAIT;
            w_enter      = 1'b1;
            w_sel        = SEL_PASSENGER_DELAY;
          end
        end
        S_TRIGGER_WAIT: begin
          if (w_expired) begin
            w_next_state = S_ALARM;
            w_enter      = 1'b1;
            w_sel        = SEL_ALARM_ON;
          end
        end
        S_ALARM: begin
          if (w_expired) begin
            if (w_any_door) begin
              w_next_state = S_ALARM;
              w_enter      = 1'b1;
              w_sel        = SEL_ALARM_ON;
            end else begin
              w_next_state = S_ARMED;
            end
          end
        end
        default: begin
          w_next_state = S_DISARMED;
        end
      endcase
    end
  end

  // Siren and LED next values, decoded from the state being entered
  always_comb begin
    w_siren_next  = 1'b0;
    w_status_next = 1'b0;
    case (w_next_state)
      S_ARMED: begin
        if (r_state != S_ARMED) begin
          w_status_next = 1'b0;
        end else begin
          w_status_next = one_hz_enable ? ~r_status : r_status;
        end
      end
      S_TRIGGER_WAIT: begin
        w_status_next = 1'b1;
      end
      S_ALARM: begin
        w_status_next = 1'b1;
`ifdef ALARM_SIREN_PULSE_EN
        if (w_enter) begin
          w_siren_next = 1'b1;
        end else begin
          w_siren_next = one_hz_enable ? ~r_siren : r_siren;
        end
`else
        w_siren_next = 1'b1;
`endif
      end
      default: begin
        w_siren_next  = 1'b0;
        w_status_next = 1'b0;
      end
    endcase
  end

  // Registered outputs: parameter select, siren and status LED
  always_ff @(posedge clock) begin
    if (reset) begin
      r_interval <= SEL_ARM_DELAY;
      r_siren    <= 1'b0;
      r_status   <= 1'b0;
    end else begin
      r_interval <= w_sel;
      r_siren    <= w_siren_next;
      r_status   <= w_status_next;
    end
  end

  // Countdown timer: wait out the parameter fetch, load, then count ticks
  always_ff @(posedge clock) begin
    if (reset) begin
      r_timer    <= '0;
      r_load_cnt <= '0;
      r_loaded   <= 1'b0;
    end else if (w_abort) begin
      r_timer    <= '0;
      r_load_cnt <= '0;
      r_loaded   <= 1'b0;
    end else if (w_enter) begin
      r_load_cnt <= LOAD_START;
      r_loaded   <= 1'b0;
    end else if (r_load_cnt != '0) begin
      r_load_cnt <= r_load_cnt - LOAD_LAST;
      if (r_load_cnt == LOAD_LAST) begin
        r_timer  <= value;
        r_loaded <= 1'b1;
      end
    end else if (r_loaded && one_hz_enable && (r_timer != '0)) begin
      r_timer <= r_timer - 1'b1;
    end
  end

  assign interval         = r_interval;
  assign siren            = r_siren;
  assign status_indicator = r_status;
  assign state_out        = r_state;
  assign timer_count      = r_timer;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Testbench for alarm_sequencer: directed test-plan scenarios followed by
// randomized stimulus, checked cycle by cycle against a behavioural model
// through an expectation queue.
module tb_alarm_sequencer;

  localparam int unsigned TW  = 5;
  localparam int          LAT = 2;

  localparam int DIS = 0;
  localparam int AW  = 1;
  localparam int ARM = 2;
  localparam int TWT = 3;
  localparam int ALM = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          ignition;
  logic          driver_door;
  logic          passenger_door;
  logic          reprogram;
  logic          one_hz_enable;
  logic [TW-1:0] value;
  logic [1:0]    interval;
  logic          siren;
  logic          status_indicator;
  logic [2:0]    state_out;
  logic [TW-1:0] timer_count;

  int tbl [4];
  int checks   = 0;
  int failures = 0;

  typedef struct {
    int st;
    int iv;
    int sir;
    int led;
    int tmr;
  } exp_t;

  exp_t q[$];

  int m_st, m_iv, m_sir, m_led, m_tmr, m_fetch;
  bit m_loaded;

  alarm_sequencer #(.TIMER_WIDTH(TW), .PARAM_LATENCY(LAT)) dut (
    .clock            (clock),
    .reset            (reset),
    .ignition         (ignition),
    .driver_door      (driver_door),
    .passenger_door   (passenger_door),
    .reprogram        (reprogram),
    .one_hz_enable    (one_hz_enable),
    .value            (value),
    .interval         (interval),
    .siren            (siren),
    .status_indicator (status_indicator),
    .state_out        (state_out),
    .timer_count      (timer_count)
  );

  always #5 clock = ~clock;

  // Parameter block: one registered table lookup on the selected interval
  always @(posedge clock) value <= TW'(tbl[interval]);

  task automatic cmp(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference model: what the alarm should show after each clock edge
  always @(posedge clock) begin : model
    int ns;
    bit ent, abt, anyd, expd;
    if (reset) begin
      m_st = DIS; m_iv = 0; m_sir = 0; m_led = 0; m_tmr = 0; m_fetch = 0; m_loaded = 0;
    end else begin
      anyd = driver_door || passenger_door;
      expd = m_loaded && (m_tmr == 0);
      ns = m_st; ent = 0; abt = 0;
      if (ignition || reprogram) begin
        ns = DIS; abt = 1;
      end else begin
        case (m_st)
          DIS: if (!anyd) begin ns = AW; ent = 1; end
          AW:  if (anyd) begin ns = AW; ent = 1; end else if (expd) ns = ARM;
          ARM: if (anyd) begin ns = TWT; ent = 1; end
          TWT: if (expd) begin ns = ALM; ent = 1; end
          ALM: if (expd) begin ns = anyd ? ALM : ARM; ent = anyd; end
          default: ns = DIS;
        endcase
      end
      if (ns == ARM)
        m_led = (m_st != ARM) ? 0 : (one_hz_enable ? 1 - m_led : m_led);
      else if (ns == TWT || ns == ALM)
        m_led = 1;
      else
        m_led = 0;
      if (ns == ALM) begin
`ifdef ALARM_SIREN_PULSE_EN
        m_sir = ent ? 1 : (one_hz_enable ? 1 - m_sir : m_sir);
`else
        m_sir = 1;
`endif
      end else begin
        m_sir = 0;
      end
      if (ent) m_iv = (ns == AW) ? 0 : (ns == ALM) ? 3 : (driver_door ? 1 : 2);
      if (abt) begin
        m_tmr = 0; m_loaded = 0; m_fetch = 0;
      end else if (ent) begin
        m_fetch = LAT; m_loaded = 0;
      end else if (m_fetch > 0) begin
        m_fetch--;
        if (m_fetch == 0) begin
          m_tmr = int'(value); m_loaded = 1;
        end
      end else if (m_loaded && one_hz_enable && m_tmr > 0) begin
        m_tmr--;
      end
      m_st = ns;
    end
    q.push_back('{m_st, m_iv, m_sir, m_led, m_tmr});
  end

  // Monitor: pop the expectation for the last edge and compare all outputs
  always @(negedge clock) begin : monitor
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      cmp("sb_state",  int'(state_out),        e.st);
      cmp("sb_interval", int'(interval),       e.iv);
      cmp("sb_siren",  int'(siren),            e.sir);
      cmp("sb_status", int'(status_indicator), e.led);
      cmp("sb_timer",  int'(timer_count),      e.tmr);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      one_hz_enable = 1'b1;
      @(negedge clock);
      one_hz_enable = 1'b0;
      @(negedge clock);
    end
  endtask

  task automatic pulse_in(input bit d, input bit p, input bit ig, input bit rp);
    driver_door = d; passenger_door = p; ignition = ig; reprogram = rp;
    @(negedge clock);
    driver_door = 1'b0; passenger_door = 1'b0; ignition = 1'b0; reprogram = 1'b0;
  endtask

  // From DISARMED with everything idle: ARM_WAIT, load 6, count it down
  task automatic arm_up();
    idle(1);
    cmp("rearm_wait", int'(state_out), AW);
    idle(2);
    tick_n(6);
    cmp("rearm_armed", int'(state_out), ARM);
  endtask

  initial begin
    bit dd, pd;
    tbl[0] = 6; tbl[1] = 8; tbl[2] = 15; tbl[3] = 10;
    reset = 1'b1; ignition = 1'b0; driver_door = 1'b0; passenger_door = 1'b0;
    reprogram = 1'b0; one_hz_enable = 1'b0;
    idle(3);
    cmp("rst_state", int'(state_out), DIS);
    cmp("rst_timer", int'(timer_count), 0);
    cmp("rst_siren", int'(siren), 0);
    reset = 1'b0;

    // Arming
    idle(1);
    cmp("arm_state", int'(state_out), AW);
    cmp("arm_interval", int'(interval), 0);
    idle(2);
    cmp("arm_load", int'(timer_count), 6);
    tick_n(5);
    cmp("arm_still_wait", int'(state_out), AW);
    cmp("arm_timer_1", int'(timer_count), 1);
    tick_n(1);
    cmp("armed_state", int'(state_out), ARM);
    cmp("armed_led", int'(status_indicator), 0);

    // Driver trigger through to ALARM
    pulse_in(1, 0, 0, 0);
    cmp("drv_state", int'(state_out), TWT);
    cmp("drv_interval", int'(interval), 1);
    idle(2);
    cmp("drv_timer", int'(timer_count), 8);
    tick_n(8);
    cmp("alarm_state", int'(state_out), ALM);
    cmp("alarm_interval", int'(interval), 3);
    cmp("alarm_siren", int'(siren), 1);
    idle(2);
    cmp("alarm_timer", int'(timer_count), 10);

    // Door held at ALARM expiry re-enters ALARM, closed doors return to ARMED
    passenger_door = 1'b1;
    tick_n(10);
    cmp("repeat_state", int'(state_out), ALM);
    cmp("repeat_timer_0", int'(timer_count), 0);
    idle(2);
    cmp("repeat_reload", int'(timer_count), 10);
    passenger_door = 1'b0;
    tick_n(10);
    cmp("exit_state", int'(state_out), ARM);
    cmp("exit_siren", int'(siren), 0);

    // Both doors together: driver select wins; then ignition abort
    pulse_in(1, 1, 0, 0);
    cmp("both_interval", int'(interval), 1);
    idle(2);
    tick_n(2);
    cmp("both_timer", int'(timer_count), 6);
    pulse_in(0, 0, 1, 0);
    cmp("ign_state", int'(state_out), DIS);
    cmp("ign_timer", int'(timer_count), 0);
    cmp("ign_siren", int'(siren), 0);
    arm_up();

    // Passenger path, then reprogram abort mid-ALARM
    pulse_in(0, 1, 0, 0);
    cmp("pas_interval", int'(interval), 2);
    idle(2);
    cmp("pas_timer", int'(timer_count), 15);
    tick_n(15);
    cmp("pas_alarm", int'(state_out), ALM);
    idle(2);
    tick_n(3);
    pulse_in(0, 0, 0, 1);
    cmp("rp_state", int'(state_out), DIS);
    cmp("rp_timer", int'(timer_count), 0);
    cmp("rp_siren", int'(siren), 0);
    arm_up();

    // Reset mid-ALARM
    pulse_in(1, 0, 0, 0);
    idle(2);
    tick_n(8);
    idle(2);
    reset = 1'b1;
    idle(1);
    cmp("mrst_state", int'(state_out), DIS);
    cmp("mrst_interval", int'(interval), 0);
    cmp("mrst_siren", int'(siren), 0);
    cmp("mrst_led", int'(status_indicator), 0);
    cmp("mrst_timer", int'(timer_count), 0);

    // Zero ARM_DELAY: ARMED without any tick
    tbl[0] = 0;
    reset = 1'b0;
    idle(3);
    cmp("zero_wait", int'(state_out), AW);
    idle(1);
    cmp("zero_armed", int'(state_out), ARM);

    // Ticks during the fetch window are ignored
    tbl[0] = 6;
    pulse_in(0, 0, 0, 1);
    idle(1);
    cmp("early_wait", int'(state_out), AW);
    one_hz_enable = 1'b1;
    idle(2);
    one_hz_enable = 1'b0;
    cmp("early_load", int'(timer_count), 6);
    idle(1);
    cmp("early_hold", int'(timer_count), 6);
    tick_n(1);
    cmp("early_dec", int'(timer_count), 5);

    // Randomized phase
    for (int i = 0; i < 4; i++) tbl[i] = int'($urandom_range(0, 6));
    dd = 0; pd = 0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 11) == 0) dd = !dd;
      if ($urandom_range(0, 11) == 0) pd = !pd;
      driver_door    = dd;
      passenger_door = pd;
      ignition       = ($urandom_range(0, 79) == 0);
      reprogram      = ($urandom_range(0, 149) == 0);
      one_hz_enable  = ($urandom_range(0, 2) == 0);
      reset          = ($urandom_range(0, 999) == 0);
      if (c % 1000 == 999) tbl[$urandom_range(0, 3)] = int'($urandom_range(0, 9));
      @(negedge clock);
    end
    reset = 1'b0; ignition = 1'b0; reprogram = 1'b0; one_hz_enable = 1'b0;
    driver_door = 1'b0; passenger_door = 1'b0;
    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
